// File: rtl/serial_add_pkg.sv
// Shared types and constants for the digit-serial adder.
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;
  localparam int DIGIT_W = 2;
endpackage

// File: rtl/two_bit_adder.sv
// Combinational 2-bit ripple slice: {Cout,sum} = a + b + Cin.
module two_bit_adder (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       Cin,
  output logic [1:0] sum,
  output logic       Cout
);
  assign {Cout, sum} = {1'b0, a} + {1'b0, b} + {2'b00, Cin};
endmodule

// File: rtl/serial_adder_seq.sv
// Sequential WIDTH-bit adder: one 2-bit digit per clock through a
// two_bit_adder slice, LSB digit first, with a registered inter-digit carry.
module serial_adder_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);
  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("serial_adder_seq: WIDTH must be even and >= 2");
  end

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [DIGIT_W-1:0] s_a, s_b, s_sum;
  logic               s_cout;

  two_bit_adder u_slice (
    .a   (s_a),
    .b   (s_b),
    .Cin (carry_q),
    .sum (s_sum),
    .Cout(s_cout)
  );

  always_comb begin
    s_a = '0;
    s_b = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        s_a = opa_q[DIGIT_W*i +: DIGIT_W];
        s_b = opb_q[DIGIT_W*i +: DIGIT_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = op_a;
          opb_d   = op_b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NDIG; i++) begin
          if (cnt_q == CNT_W'(i)) result_d[DIGIT_W*i +: DIGIT_W] = s_sum;
        end
        carry_d = s_cout;
        if (cnt_q == LAST) begin
          cout_d  = s_cout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status flags are registered alongside the state they describe.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
endmodule
